// File: rtl/framed_packet_tx.sv
// rtl/framed_packet_tx.sv - byte-serial framing transmitter with escaping, XOR checksum and backpressure
module framed_packet_tx #(
  parameter int          DATA_BYTES = 4,
  parameter bit          CSUM_EN    = 1'b1,
  parameter logic [7:0]  FLAG       = 8'h7E,
  parameter logic [7:0]  ESC        = 8'h7D,
  parameter logic [7:0]  ESC_XOR    = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_BYTES*8-1:0] in_data,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int DW = DATA_BYTES * 8;
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_DESC, S_CSUM, S_CESC, S_END
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] shreg;
  logic [IW-1:0] idx;
  logic [7:0]    csum;
  logic          frame_done_q;

  logic [7:0] cur;
  logic       cur_esc, csum_esc, is_last, beat, capture, data_adv;

  // The current data byte always sits at the top of the shift register
  assign cur      = shreg[DW-1 -: 8];
  assign cur_esc  = (cur == FLAG) || (cur == ESC);
  assign csum_esc = (csum == FLAG) || (csum == ESC);
  assign is_last  = (idx == LAST);
  assign beat     = tx_valid && tx_ready;
  assign capture  = in_valid && in_ready;
  // A raw data byte is consumed either by its plain beat or by the second half of its escape pair
  assign data_adv = beat && (((state == S_DATA) && !cur_esc) || (state == S_DESC));

  // State register plus packet datapath; capture has priority since it only happens in IDLE or on the END beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      idx          <= '0;
      csum         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nx;
      frame_done_q <= beat && (state == S_END);
      if (capture) begin
        shreg <= in_data;
        csum  <= '0;
        idx   <= '0;
      end else if (data_adv) begin
        csum  <= csum ^ cur;
        shreg <= shreg << 8;
        if (!is_last) idx <= idx + IW'(1);
      end
    end
  end

  // Next-state decode; every transition out of a transmitting state waits for a beat
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_START;
      S_START: if (beat) state_nx = S_DATA;
      S_DATA, S_DESC: begin
        if (beat) begin
          if ((state == S_DATA) && cur_esc) state_nx = S_DESC;
          else if (!is_last)                state_nx = S_DATA;
          else if (CSUM_EN)                 state_nx = S_CSUM;
          else                              state_nx = S_END;
        end
      end
      S_CSUM:  if (beat) state_nx = csum_esc ? S_CESC : S_END;
      S_CESC:  if (beat) state_nx = S_END;
      S_END:   if (beat) state_nx = in_valid ? S_START : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode; tx_byte depends only on registered state so it holds through stalls
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_START: tx_byte = FLAG;
      S_DATA:  tx_byte = cur_esc ? ESC : cur;
      S_DESC:  tx_byte = cur ^ ESC_XOR;
      S_CSUM:  tx_byte = csum_esc ? ESC : csum;
      S_CESC:  tx_byte = csum ^ ESC_XOR;
      S_END:   tx_byte = FLAG;
      default: tx_byte = 8'h00;
    endcase
    tx_valid   = (state != S_IDLE);
    busy       = (state != S_IDLE);
    in_ready   = (state == S_IDLE) || ((state == S_END) && tx_ready);
    frame_done = frame_done_q;
  end

endmodule
